alu_pipelined: RTL

- Parametrised, handshaked successor to the combinational `execute_alu` datapath.
- Accepts one operation per transaction over a valid/ready input channel and holds the result until it is consumed on a valid/ready output channel.
- Single-cycle ops return after 1 cycle. Multiply runs as an iterative shift-add over WIDTH cycles.
- Sits between the instruction-issue stage and the writeback register in the execute pipeline.

---
 rtl/alu_pkg.sv | 60 ++++++
 rtl/alu_mul_iter.sv | 52 +++++
 rtl/alu_pipelined.sv | 94 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and the single-cycle ALU function for the execute-stage ALU.
// The function works on a MAX_W-wide datapath and masks its result down to the caller's width.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned MAX_W = 64;

    typedef struct packed {
        logic             carry;
        logic [MAX_W-1:0] res;
    } alu_res_t;

    // Operands must already be zero-extended from w bits; w is a power of two.
    function automatic alu_res_t alu_single(input alu_op_e op, input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b, input int unsigned w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] sh;
        logic [MAX_W:0]   sum;
        alu_res_t         r;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        sh   = b & MAX_W'(w - 1);
        sum  = {1'b0, a} + {1'b0, b};
        r    = '0;
        case (op)
            ALU_ADD: begin
                r.res   = sum[MAX_W-1:0];
                r.carry = |(sum >> w);
            end
            ALU_SUB: begin
                r.res   = a - b;
                r.carry = (a < b);
            end
            ALU_AND: r.res = a & b;
            ALU_OR:  r.res = a | b;
            ALU_XOR: r.res = a ^ b;
            ALU_SHL: r.res = a << sh;
            ALU_SHR: r.res = a >> sh;
            default: r.res = '0;
        endcase
        r.res = r.res & mask;
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// `product` is the running sum including this cycle's step, so it is final while `done` is high.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    count;

    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign done     = busy && (count == CW'(WIDTH - 1));
    assign product  = acc_next;

    // NOTE: every register updated on the clock edge uses <= so all of them see pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_pipelined.sv
// Handshaked execute ALU: single-cycle ops finish in one cycle, MUL is handed to the
// iterative multiplier; the result is held until the consumer takes it.
module alu_pipelined
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  config_,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry,
    output logic             zero
);

    state_e           state;
    state_e           state_next;
    alu_op_e          op;
    alu_res_t         single;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign op        = alu_op_e'(config_);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == ALU_MUL);
    assign single    = alu_single(op, MAX_W'(a), MAX_W'(b), WIDTH);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .CLK     (CLK),
        .RESET   (RESET),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = mul_start ? BUSY : DONE;
            BUSY:    if (mul_done) state_next = DONE;
            DONE: begin
                if (accept)
                    state_next = mul_start ? BUSY : DONE;
                else if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == DONE);
        in_ready  = ((state == IDLE) || ((state == DONE) && out_ready)) && !mul_busy;
    end

    // Result registers only move on a new result, so they hold across backpressure and hand-off.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            c     <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (accept && !mul_start) begin
            c     <= single.res[WIDTH-1:0];
            carry <= single.carry;
            zero  <= (single.res == '0);
        end else if (mul_done) begin
            c     <= mul_product;
            carry <= 1'b0;
            zero  <= (mul_product == '0);
        end
    end

endmodule
